key_conditioner: RTL and testbench

// - Conditions the raw board keys before they reach the counter-period control and other user logic.
// - Per key: 2-FF synchroniser, debounce filter, and one-cycle press/release pulses.
// - Optional hold-to-repeat pulse train, so a held key steps a value at a controlled rate.
// - Sits between the key[] input of the top level and the logic consuming key events.

---
 rtl/key_conditioner_if.sv | 27 ++
 rtl/key_conditioner.sv | 151 +++++++++++++++
 tb/tb_key_conditioner.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Key bundle between the board key pins and the key conditioner.
// The master side drives the raw keys; the slave side is the conditioner producing key events.
interface key_conditioner_if #(
    parameter int n_keys = 8
);
    logic [n_keys-1:0] key_raw;
    logic [n_keys-1:0] key_level;
    logic [n_keys-1:0] key_press;
    logic [n_keys-1:0] key_release;
    logic [n_keys-1:0] key_repeat;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_repeat
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release,
        output key_repeat
    );
endinterface

// File: rtl/key_conditioner.sv
// Key conditioner: per-key 2-FF synchroniser, debounce filter and one-cycle press/release pulses.
// Define KEY_CONDITIONER_REPEAT_EN to build the hold-to-repeat pulse train on key_repeat.
module key_conditioner #(
    parameter int n_keys          = 8,
    parameter int debounce_cycles = 270_000,
    parameter int repeat_delay    = 13_500_000,
    parameter int repeat_period   = 2_700_000
) (
    input  logic             clock,
    input  logic             reset,
    key_conditioner_if.slave keys
);

    localparam int DW = $clog2(debounce_cycles + 1);

    if (debounce_cycles < 1 || repeat_delay < 1 || repeat_period < 1) begin : g_param_check
        $error("key_conditioner: debounce_cycles, repeat_delay and repeat_period must be >= 1");
    end

    logic [n_keys-1:0] sync1_r;
    logic [n_keys-1:0] sync2_r;
    logic [n_keys-1:0] level_r;
    logic [n_keys-1:0] press_r;
    logic [n_keys-1:0] release_r;
    logic [DW-1:0]     cnt_r [n_keys];
    logic [n_keys-1:0] rise_s;
    logic [n_keys-1:0] fall_s;

    // A change is accepted once the synchronised key has disagreed with the level for debounce_cycles samples
    always_comb begin
        rise_s = '0;
        fall_s = '0;
        for (int k = 0; k < n_keys; k++) begin
            if ((sync2_r[k] != level_r[k]) && (cnt_r[k] == DW'(debounce_cycles - 1))) begin
                rise_s[k] = sync2_r[k];
                fall_s[k] = ~sync2_r[k];
            end else begin
                rise_s[k] = 1'b0;
                fall_s[k] = 1'b0;
            end
        end
    end

    // Synchroniser, debounce counters, debounced level and edge pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r   <= '0;
            sync2_r   <= '0;
            level_r   <= '0;
            press_r   <= '0;
            release_r <= '0;
            for (int k = 0; k < n_keys; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            sync1_r   <= keys.key_raw;
            sync2_r   <= sync1_r;
            level_r   <= level_r ^ (rise_s | fall_s);
            press_r   <= rise_s;
            release_r <= fall_s;
            for (int k = 0; k < n_keys; k++) begin
                if ((sync2_r[k] == level_r[k]) || rise_s[k] || fall_s[k]) begin
                    cnt_r[k] <= '0;
                end else begin
                    cnt_r[k] <= cnt_r[k] + DW'(1);
                end
            end
        end
    end

    assign keys.key_level   = level_r;
    assign keys.key_press   = press_r;
    assign keys.key_release = release_r;

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int RMAX = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
    localparam int TW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    rep_state_t        state_r [n_keys];
    rep_state_t        state_s [n_keys];
    logic [TW-1:0]     timer_r [n_keys];
    logic [TW-1:0]     timer_s [n_keys];
    logic [n_keys-1:0] repeat_r;
    logic [n_keys-1:0] repeat_s;

    // Repeat FSM state, timers and registered repeat pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            repeat_r <= '0;
            for (int k = 0; k < n_keys; k++) begin
                state_r[k] <= IDLE;
                timer_r[k] <= '0;
            end
        end else begin
            repeat_r <= repeat_s;
            for (int k = 0; k < n_keys; k++) begin
                state_r[k] <= state_s[k];
                timer_r[k] <= timer_s[k];
            end
        end
    end

    // Next state per key; an accepted release always wins over a timer expiry
    always_comb begin
        repeat_s = '0;
        for (int k = 0; k < n_keys; k++) begin
            state_s[k]  = state_r[k];
            timer_s[k]  = timer_r[k];
            repeat_s[k] = 1'b0;
            case (state_r[k])
                IDLE: begin
                    if (rise_s[k]) begin
                        repeat_s[k] = 1'b1;
                        timer_s[k]  = TW'(repeat_delay - 1);
                        state_s[k]  = DELAY;
                    end else begin
                        state_s[k] = IDLE;
                    end
                end
                DELAY, REPEAT: begin
                    if (fall_s[k]) begin
                        state_s[k] = IDLE;
                        timer_s[k] = '0;
                    end else if (timer_r[k] == TW'(0)) begin
                        repeat_s[k] = 1'b1;
                        timer_s[k]  = TW'(repeat_period - 1);
                        state_s[k]  = REPEAT;
                    end else begin
                        timer_s[k] = timer_r[k] - TW'(1);
                    end
                end
                default: begin
                    state_s[k] = IDLE;
                    timer_s[k] = '0;
                end
            endcase
        end
    end

    assign keys.key_repeat = repeat_r;
`else
    assign keys.key_repeat = press_r;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: per-cycle expected output vectors are queued when
// stimulus is driven and compared on the falling edge of the matching cycle.
module tb_key_conditioner;

    localparam int NK = 8;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int ACC = DB + 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    key_conditioner_if #(.n_keys(NK)) kif ();

    key_conditioner #(
        .n_keys(NK),
        .debounce_cycles(DB),
        .repeat_delay(RD),
        .repeat_period(RP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .keys(kif)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            cyc;
        string         name;
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] rep;
    } exp_t;

    typedef struct {
        string         name;
        logic [NK-1:0] mask;
        int            len;
    } vec_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc ||
                kif.key_level !== e.level || kif.key_press !== e.press ||
                kif.key_release !== e.rel || kif.key_repeat !== e.rep) begin
                errors++;
                $display("FAIL %s cyc=%0d(want %0d) got lvl=%h prs=%h rel=%h rep=%h want lvl=%h prs=%h rel=%h rep=%h",
                         e.name, cyc, e.cyc, kif.key_level, kif.key_press, kif.key_release,
                         kif.key_repeat, e.level, e.press, e.rel, e.rep);
            end
        end
    end

    // d: cycles since acceptance of the press; held: cycles from acceptance to accepted release
    function automatic bit rep_due(input int d, input int held);
`ifdef KEY_CONDITIONER_REPEAT_EN
        return (d == 0) || (d >= RD && d < held && ((d - RD) % RP) == 0);
`else
        return (d == 0) && (held > 0);
`endif
    endfunction

    task automatic push_exp(input int c, input string name, input logic [NK-1:0] lvl,
                            input logic [NK-1:0] prs, input logic [NK-1:0] rel,
                            input logic [NK-1:0] rep);
        exp_t e;
        e.cyc = c; e.name = name; e.level = lvl; e.press = prs; e.rel = rel; e.rep = rep;
        exp_q.push_back(e);
    endtask

    // Raw keys in mask high for len cycles, then low; expectations for the whole window
    task automatic run_pulse(input string name, input logic [NK-1:0] mask, input int len);
        int s;
        int n;
        bit acc;
        s   = cyc;
        n   = len + ACC + 4;
        acc = (len >= DB);
        for (int i = 0; i < n; i++) begin
            push_exp(s + i, name,
                     (acc && i >= ACC && i < len + ACC) ? mask : '0,
                     (acc && i == ACC) ? mask : '0,
                     (acc && i == len + ACC) ? mask : '0,
                     (acc && rep_due(i - ACC, len)) ? mask : '0);
        end
        for (int i = 0; i < n; i++) begin
            kif.key_raw = (i < len) ? mask : '0;
            @(posedge clock); #1;
        end
    endtask

    // Key 3 held into the repeat phase, reset pulsed, then a fresh press and release
    task automatic run_reset_midrepeat();
        int s;
        int j;
        s = cyc;
        for (int i = 0; i < 30; i++) begin
            push_exp(s + i, "pre_reset",
                     (i >= ACC) ? 8'h08 : 8'h00,
                     (i == ACC) ? 8'h08 : 8'h00,
                     8'h00,
                     rep_due(i - ACC, 30) ? 8'h08 : 8'h00);
        end
        for (int i = 30; i < 33; i++) begin
            push_exp(s + i, "in_reset", 8'h00, 8'h00, 8'h00, 8'h00);
        end
        for (int i = 33; i < 54; i++) begin
            j = i - 33;
            push_exp(s + i, "post_reset",
                     (j >= ACC && j < 9 + ACC) ? 8'h08 : 8'h00,
                     (j == ACC) ? 8'h08 : 8'h00,
                     (j == 9 + ACC) ? 8'h08 : 8'h00,
                     rep_due(j - ACC, 9) ? 8'h08 : 8'h00);
        end
        for (int i = 0; i < 54; i++) begin
            if (i == 30) reset = 1'b1;
            if (i == 33) reset = 1'b0;
            kif.key_raw = (i < 42) ? 8'h08 : 8'h00;
            @(posedge clock); #1;
        end
    endtask

    initial begin
        vec_t tbl[9];
        tbl[0] = '{"glitch_3clk",     8'h01, 3};
        tbl[1] = '{"glitch_1clk",     8'h01, 1};
        tbl[2] = '{"min_press",       8'h01, 4};
        tbl[3] = '{"clean_press",     8'h01, 12};
        tbl[4] = '{"hold_repeat",     8'h04, 40};
        tbl[5] = '{"rel_first_expiry", 8'h40, 20};
        tbl[6] = '{"rel_mid_period",  8'h80, 27};
        tbl[7] = '{"simultaneous",    8'h22, 12};
        tbl[8] = '{"all_keys",        8'hFF, 30};

        kif.key_raw = '0;
        reset = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            push_exp(cyc + i, "reset_state", 8'h00, 8'h00, 8'h00, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            reset = (i < 2);
            @(posedge clock); #1;
        end

        for (int t = 0; t < 9; t++) begin
            run_pulse(tbl[t].name, tbl[t].mask, tbl[t].len);
        end

        run_reset_midrepeat();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clock); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time=%0t limit reached", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
